// File: rtl/add3_seq_datapath_if.sv
// ============================================================================
// Module      : add3_seq_datapath_if
// Description : Start/done handshake and operand/result bus for add3_seq_datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface add3_seq_datapath_if #(
    parameter int WIDTH = 6
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             use_c;
    logic             acc;
    logic             ready;
    logic             done;
    logic [WIDTH+1:0] result;
    logic             ovf;

    modport master (
        output start, a, b, c, use_c, acc,
        input  ready, done, result, ovf
    );

    modport slave (
        input  start, a, b, c, use_c, acc,
        output ready, done, result, ovf
    );
endinterface

`default_nettype wire

// File: rtl/add3_seq_datapath.sv
// ============================================================================
// Module      : add3_seq_datapath
// Description : FSM-controlled A + B + (C | OFFSET) adder, one adder reused
//               over two cycles, with accumulate mode and optional saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add3_seq_datapath #(
    parameter int          WIDTH  = 6,
    parameter int unsigned OFFSET = 3,
    parameter int          SAT    = 0
) (
    input  wire logic             CLK,
    input  wire logic             RST_N,
    add3_seq_datapath_if.slave    bus
);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ADD1 = 2'd1;
    localparam logic [1:0] c_ADD2 = 2'd2;
    localparam logic [1:0] c_OUT  = 2'd3;

    localparam logic [WIDTH-1:0] c_OFFSET = OFFSET[WIDTH-1:0];
    localparam logic [WIDTH+1:0] c_MAX    = {2'b00, {WIDTH{1'b1}}};

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_op_c;
    logic [WIDTH:0]   r_x;
    logic [WIDTH+1:0] r_y;
    logic [WIDTH+1:0] r_result;
    logic             r_ovf;
    logic             r_done;
    logic             w_ovf;

    // Anything above the low WIDTH bits means the sum exceeded 2^WIDTH-1.
    assign w_ovf = |r_y[WIDTH+1:WIDTH];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= c_IDLE;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_op_c   <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_op_a  <= bus.acc ? r_result[WIDTH-1:0] : bus.a;
                        r_op_b  <= bus.b;
                        r_op_c  <= bus.use_c ? bus.c : c_OFFSET;
                        r_state <= c_ADD1;
                    end
                end
                c_ADD1: begin
                    r_x     <= {1'b0, r_op_a} + {1'b0, r_op_b};
                    r_state <= c_ADD2;
                end
                c_ADD2: begin
                    r_y     <= {1'b0, r_x} + {2'b00, r_op_c};
                    r_state <= c_OUT;
                end
                c_OUT: begin
                    r_ovf    <= w_ovf;
                    r_result <= ((SAT != 0) && w_ovf) ? c_MAX : r_y;
                    r_done   <= 1'b1;
                    r_state  <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.ready  = (r_state == c_IDLE);
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.ovf    = r_ovf;
endmodule

`default_nettype wire

// File: tb/tb_add3_seq_datapath.sv
// Directed bench driving a SAT=0 and a SAT=1 instance with identical stimulus.
`default_nettype none

module tb_add3_seq_datapath;
    localparam int W = 6;

    logic CLK = 1'b0;
    logic RST_N;
    int   n_vec = 0;
    int   n_err = 0;

    add3_seq_datapath_if #(.WIDTH(W)) u_if0 ();
    add3_seq_datapath_if #(.WIDTH(W)) u_if1 ();

    assign u_if1.start = u_if0.start;
    assign u_if1.a     = u_if0.a;
    assign u_if1.b     = u_if0.b;
    assign u_if1.c     = u_if0.c;
    assign u_if1.use_c = u_if0.use_c;
    assign u_if1.acc   = u_if0.acc;

    add3_seq_datapath #(.WIDTH(W), .OFFSET(3), .SAT(0)) u_dut0 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (u_if0.slave)
    );

    add3_seq_datapath #(.WIDTH(W), .OFFSET(3), .SAT(1)) u_dut1 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (u_if1.slave)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_idle(input string tag, input int exp_res, input logic exp_ovf);
        chk({tag, ".ready"},  32'(u_if0.ready), 32'd1);
        chk({tag, ".done"},   32'(u_if0.done), 32'd0);
        chk({tag, ".result"}, 32'(u_if0.result), 32'(exp_res));
        chk({tag, ".ovf"},    32'(u_if0.ovf), 32'(exp_ovf));
    endtask

    // Issues one operation and returns in the done cycle (after edge N+3).
    task automatic run_op(input string tag, input logic [W-1:0] a, b, c,
                          input logic uc, ac, input int exp0, exp1, input logic ov);
        u_if0.a = a; u_if0.b = b; u_if0.c = c;
        u_if0.use_c = uc; u_if0.acc = ac; u_if0.start = 1'b1;
        tick();
        // Disturb every input while busy: must not affect the operation in flight.
        u_if0.a = ~a; u_if0.b = ~b; u_if0.c = ~c;
        u_if0.use_c = ~uc; u_if0.acc = ~ac;
        for (int i = 0; i < 2; i++) begin
            chk({tag, ".busy_ready"}, 32'(u_if0.ready), 32'd0);
            chk({tag, ".busy_done"},  32'(u_if0.done), 32'd0);
            tick();
        end
        chk({tag, ".busy_ready"}, 32'(u_if0.ready), 32'd0);
        tick();
        u_if0.start = 1'b0;
        chk({tag, ".done0"},   32'(u_if0.done), 32'd1);
        chk({tag, ".ready0"},  32'(u_if0.ready), 32'd1);
        chk({tag, ".result0"}, 32'(u_if0.result), 32'(exp0));
        chk({tag, ".ovf0"},    32'(u_if0.ovf), 32'(ov));
        chk({tag, ".done1"},   32'(u_if1.done), 32'd1);
        chk({tag, ".result1"}, 32'(u_if1.result), 32'(exp1));
        chk({tag, ".ovf1"},    32'(u_if1.ovf), 32'(ov));
    endtask

    initial begin
        RST_N = 1'b1;
        u_if0.start = 1'b0; u_if0.a = '0; u_if0.b = '0; u_if0.c = '0;
        u_if0.use_c = 1'b0; u_if0.acc = 1'b0;
        #2 RST_N = 1'b0;
        #2 chk_idle("reset_async", 0, 1'b0);
        @(posedge CLK); @(posedge CLK); #1;
        RST_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_idle("idle", 0, 1'b0);
        end

        run_op("basic", 6'd10, 6'd20, 6'd30, 1'b1, 1'b0, 60, 60, 1'b0);
        tick();
        chk_idle("basic_hold", 60, 1'b0);

        run_op("max", 6'd63, 6'd63, 6'd63, 1'b1, 1'b0, 189, 63, 1'b1);
        tick();
        chk({"max_hold", ".result1"}, 32'(u_if1.result), 32'd63);
        chk_idle("max_hold", 189, 1'b1);

        run_op("edge63", 6'd20, 6'd20, 6'd23, 1'b1, 1'b0, 63, 63, 1'b0);
        tick();

        run_op("offset", 6'd5, 6'd7, 6'd50, 1'b0, 1'b0, 15, 15, 1'b0);
        // Back-to-back from the done cycle: accumulate uses the fresh result.
        run_op("accum", 6'd40, 6'd1, 6'd2, 1'b1, 1'b1, 18, 18, 1'b0);

        // Continuous start: one capture per 4 cycles, nothing extra while busy.
        u_if0.a = 6'd1; u_if0.b = 6'd1; u_if0.c = 6'd1;
        u_if0.use_c = 1'b1; u_if0.acc = 1'b0; u_if0.start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) begin
                tick();
                chk("stream.busy_ready", 32'(u_if0.ready), 32'd0);
                chk("stream.busy_done",  32'(u_if0.done), 32'd0);
            end
            tick();
            chk("stream.done",   32'(u_if0.done), 32'd1);
            chk("stream.result", 32'(u_if0.result), 32'd3);
        end
        u_if0.start = 1'b0;
        tick();
        chk_idle("stream_end", 3, 1'b0);

        // Abort in ADD2 via asynchronous reset.
        u_if0.a = 6'd10; u_if0.b = 6'd10; u_if0.c = 6'd10; u_if0.start = 1'b1;
        tick();
        u_if0.start = 1'b0;
        tick();
        #2 RST_N = 1'b0;
        #1 chk_idle("abort_async", 0, 1'b0);
        tick();
        chk_idle("abort_held", 0, 1'b0);
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle("abort_after", 0, 1'b0);
        end
        run_op("post_reset", 6'd2, 6'd3, 6'd4, 1'b1, 1'b0, 9, 9, 1'b0);
        tick();
        chk_idle("final", 9, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/add3_seq_datapath.md
# add3_seq_datapath

Parametrised, FSM-controlled three-operand adder datapath with a start/done handshake. It holds its own controller, so the surrounding logic no longer drives register enables and mux selects. A single internal adder is reused over two cycles to form A + B + (C or a constant OFFSET). It adds an accumulate mode that feeds the previous result back as operand A, plus optional saturation with an overflow flag.

## Interface
Parameters:
- WIDTH, 6: operand width in bits (≥ 2).
- OFFSET, 3: constant third operand used when use_c = 0. Truncated to WIDTH bits.
- SAT, 0: 1 = clamp result to 2^WIDTH−1 on overflow; 0 = full-width result.

Ports:
- CLK  in  1  clock. All state updates on the rising edge.
- RST_N  in  1  reset. Asynchronous, active-low.
- start  in  1  request. Sampled only while ready = 1.
- a  in  WIDTH  operand A. Ignored when acc = 1.
- b  in  WIDTH  operand B.
- c  in  WIDTH  operand C. Ignored when use_c = 0.
- use_c  in  1  1 = third operand is c; 0 = third operand is OFFSET.
- acc  in  1  1 = operand A is result[WIDTH-1:0] instead of a.
- ready  out  1  high only in IDLE.
- done  out  1  registered one-cycle pulse when result is updated.
- result  out  WIDTH+2  registered sum. Holds its value between operations.
- ovf  out  1  registered. Set when the unclamped sum exceeds 2^WIDTH−1. Updated together with result.

## Operation
- Internal registers:
  - opA, opB, opC: WIDTH bits each.
  - x: WIDTH+1 bits.
  - y: WIDTH+2 bits.
  - state: 2 bits.
- States: IDLE, ADD1, ADD2, OUT.
- IDLE:
  - ready = 1.
  - On start = 1, capture at the edge:
    - opA ← acc ? result[WIDTH-1:0] : a
    - opB ← b
    - opC ← use_c ? c : OFFSET[WIDTH-1:0]
  - Then go to ADD1. Without start, stay in IDLE.
- ADD1: x ← opA + opB, zero-extended, no loss. Go to ADD2.
- ADD2: y ← x + opC, zero-extended. Go to OUT.
- OUT:
  - ovf ← (y > 2^WIDTH−1).
  - result ← (SAT && ovf_condition) ? 2^WIDTH−1 : y.
  - done ← 1. Go to IDLE.
- done is cleared on every edge where the state is not OUT.
- Maximum sum is 3·(2^WIDTH−1), which fits in WIDTH+2 bits. No wrap-around is possible when SAT = 0.
- start while ready = 0 is ignored. It is not queued.
- Inputs a, b, c, use_c and acc may change freely after the capture edge without affecting the operation in flight.
- Accumulate mode:
  - Uses result as it stands at the capture edge. This is legal in the cycle done is high, since result is already updated.
  - Upper bits result[WIDTH+1:WIDTH] are discarded.
  - After reset, result is 0.
- Reset (RST_N = 0), at any time including mid-operation:
  - state = IDLE.
  - All internal registers, result, ovf and done clear to 0 immediately.
  - The in-flight operation is abandoned and no done is produced.
  - ready = 1 once reset is released.

## Timing
- Reset values: ready = 1, done = 0, result = 0, ovf = 0.
- Latency: start sampled at edge N → result, ovf and done valid after edge N+3. done is high for exactly the cycle between edges N+3 and N+4.
- ready falls after edge N and returns high after edge N+3, in the same cycle as done.
- The earliest next capture is edge N+4. Maximum throughput is one operation per 4 cycles.
- result and ovf are stable from edge N+3 until the next completion or reset.
- ready is decoded combinationally from state. done, result and ovf come straight from flops.

## Test plan
Use WIDTH = 6 and OFFSET = 3 unless stated.
- Reset, then idle for 5 cycles → ready = 1, done = 0, result = 0, ovf = 0 throughout. Assert RST_N low asynchronously mid-cycle → outputs clear without a clock edge.
- a = 10, b = 20, c = 30, use_c = 1, start pulse at edge N → ready low for edges N+1..N+3. done is a single pulse after N+3 with result = 60, ovf = 0. Inputs changed after edge N have no effect.
- a = 63, b = 63, c = 63:
  - SAT = 0 → result = 189, ovf = 1.
  - Separate instance with SAT = 1 → result = 63, ovf = 1.
  - a = 20, b = 20, c = 23 → result = 63, ovf = 0 on both instances.
- use_c = 0, a = 5, b = 7, c = 50 → result = 15. Then acc = 1, a = 40, b = 1, c = 2, use_c = 1, started in the done cycle → result = 18, captured on the earliest allowed edge.
- Hold start high continuously with a = 1, b = 1, c = 1 → one capture every 4 cycles, done every 4 cycles, result = 3 each time. No extra capture while ready = 0.
- Assert reset while in ADD2 → no done, result = 0. A following a = 2, b = 3, c = 4 operation → result = 9 with nominal latency.
